ram_burst_master: RTL and testbench
===================================

// Module: ram_burst_master
// PURPOSE
//  Initiator for the single-port ram: takes burst read/write commands on a
//  valid/ready port and drives the ram en/wr_rd/addr/data_in pins. Streams
//  write data in and read data out. Reads wait for the ram's out_en
//  strobe; a missing strobe aborts the burst with a timeout error.
//  Sits between the system datapath and the ram.
// PARAMETERS
//  DATA_WIDTH  8   data word width; equals `data_width
//  ADDR_WIDTH  4   ram address width; equals `addr_width
//  LEN_WIDTH   4   burst length field; beats = cmd_len+1 (1..16)
//  TIMEOUT     8   max cycles in RD_WAIT before abort (>=2)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   high only in IDLE
//  cmd_wr       in   1   1=write burst, 0=read burst
//  cmd_addr     in   AW  start address
//  cmd_len      in   LW  beats-1
//  wr_data      in   DW  write beat data
//  wr_valid     in   1   write beat present
//  wr_ready     out  1   high in WR state
//  rd_data      out  DW  read beat data (registered)
//  rd_valid     out  1   1-cycle pulse per read beat; no backpressure
//  done         out  1   1-cycle pulse: burst completed
//  err_timeout  out  1   1-cycle pulse: read aborted
//  ram_en       out  1   to ram en
//  ram_wr_rd    out  1   to ram wr_rd (1=write)
//  ram_addr     out  AW  to ram addr
//  ram_wdata    out  DW  to ram data_in
//  ram_rdata    in   DW  from ram data_out
//  ram_out_en   in   1   from ram out_en
// BEHAVIOUR
//  Reset (async, any state): state=IDLE. rd_data=0, rd_valid=0, done=0,
//   err_timeout=0. ram_en=0, ram_wr_rd=0, ram_addr=0. The burst in flight
//   is dropped with no done and no err_timeout.
//  States: IDLE, WR, RD_ISSUE, RD_WAIT.
//  IDLE: cmd_ready=1. On cmd_valid, latch addr, beat count and cmd_wr.
//   Next state is WR if cmd_wr=1, else RD_ISSUE.
//  WR: wr_ready=1. ram_en=wr_valid, ram_wr_rd=1, ram_addr=addr_q,
//   ram_wdata=wr_data, all combinational.
//   - Each edge with wr_valid commits one beat, then addr+1 and count-1.
//   - wr_valid=0 inserts a bubble with ram_en=0.
//   - After the last commit, go to IDLE and assert done the next cycle.
//  RD_ISSUE: ram_en=1, ram_wr_rd=0, ram_addr=addr_q, for exactly 1 cycle.
//   Then RD_WAIT with the timer cleared.
//  RD_WAIT: ram_en=0, timer counts up each cycle.
//   - On ram_out_en=1: rd_data<=ram_rdata, rd_valid=1 next cycle,
//     addr+1, count-1. Next state is RD_ISSUE, or IDLE after the last beat.
//     On the last beat, done pulses in the same cycle as the final rd_valid.
//   - If the timer reaches TIMEOUT with no out_en: err_timeout pulses next
//     cycle and the FSM returns to IDLE. Remaining beats are dropped and
//     done is not asserted.
//   - ram_out_en outside RD_WAIT is ignored.
//  Read latency: issue in cycle N, ram_out_en in N+1, rd_valid in N+2.
//   Minimum 2 cycles per read beat, 1 cycle per write beat.
//  Address wraps modulo 2**ADDR_WIDTH (0xF+1 -> 0x0). No error on wrap.
//  cmd_len=0 gives a single beat. cmd_len=all-ones gives 16 beats.
//  A new command may be accepted in the same cycle as done or
//   err_timeout, because the FSM is already in IDLE.
// STRUCTURE
//  defines.v already holds `data_width/`addr_width; add `len_width, the
//   `timeout default, and the state encodings (`S_IDLE..`S_RD_WAIT, 2 bits).
//  Sub-module: ram_timeout_counter (clear, enable, expired). It is reused
//   by later initiators.
// TESTING  (bench instantiates the ram model with en tied via ram_en)
//  1 Write addr=3,len=3, data A0..A3 back-to-back: mem[3..6]=A0..A3,
//    4 commit cycles, done 1 cycle after last commit.
//  2 Read addr=3,len=3: rd_valid x4 with A0..A3 every 2 cycles, first
//    rd_valid 3 cycles after accept, done with 4th rd_valid.
//  3 Write addr=E,len=2 with a 2-cycle wr_valid gap: mem[E],mem[F],mem[0]
//    written, ram_en=0 during gap.
//  4 Read with ram_out_en forced 0, TIMEOUT=8: err_timeout pulses once,
//    no rd_valid, no done, cmd_ready=1 afterwards.
//  5 Assert rst mid read burst (beat 2 of 4): all outputs 0 immediately,
//    next command accepted cleanly; cmd_valid held in done cycle is accepted.

Source files
------------

// File: rtl/ram_burst_master_pkg.sv
// ram_burst_master_pkg: shared widths, timeout default and FSM state encoding for the ram burst master.
package ram_burst_master_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_LEN_WIDTH  = 4;
    localparam int DEF_TIMEOUT    = 8;
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR       = 2'd1,
        S_RD_ISSUE = 2'd2,
        S_RD_WAIT  = 2'd3
    } state_t;
endpackage

// File: rtl/ram_burst_master_if.sv
// ram_burst_master_if: command, write/read stream and ram pin bundle of the burst master.
interface ram_burst_master_if
    import ram_burst_master_pkg::*;
#(
    parameter int DW = DEF_DATA_WIDTH,
    parameter int AW = DEF_ADDR_WIDTH,
    parameter int LW = DEF_LEN_WIDTH
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          done;
    logic          err_timeout;
    logic          ram_en;
    logic          ram_wr_rd;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_out_en;
    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid, ram_rdata, ram_out_en,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, err_timeout,
               ram_en, ram_wr_rd, ram_addr, ram_wdata
    );
    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid, ram_rdata, ram_out_en,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, err_timeout,
               ram_en, ram_wr_rd, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_burst_master_timeout.sv
// ram_timeout_counter: saturating wait timer; o_expired marks the LIMIT-th enabled cycle since clear.
module ram_timeout_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = $clog2(LIMIT);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (i_clear) r_cnt <= '0;
        else if (i_enable && !o_expired) r_cnt <= r_cnt + 1'b1;
    assign o_expired = r_cnt == W'(LIMIT - 1);
endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master: burst read/write initiator driving the single-port ram, with read timeout abort.
module ram_burst_master
    import ram_burst_master_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input logic clk,
    input logic rst,
    ram_burst_master_if.master m
);
    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid, r_done, r_err;
    logic                  w_wr_beat, w_rd_beat, w_last, w_expired;
    assign w_wr_beat = r_state == S_WR && m.wr_valid;
    assign w_rd_beat = r_state == S_RD_WAIT && m.ram_out_en;
    assign w_last    = r_cnt == '0;
    ram_timeout_counter #(.LIMIT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == S_RD_ISSUE),
        .i_enable  (r_state == S_RD_WAIT),
        .o_expired (w_expired)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = m.cmd_valid ? (m.cmd_wr ? S_WR : S_RD_ISSUE) : S_IDLE;
            S_WR:       w_next = w_wr_beat && w_last ? S_IDLE : S_WR;
            S_RD_ISSUE: w_next = S_RD_WAIT;
            S_RD_WAIT:  w_next = w_rd_beat ? (w_last ? S_IDLE : S_RD_ISSUE) : (w_expired ? S_IDLE : S_RD_WAIT);
            default:    w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= w_rd_beat;
            r_done     <= (w_wr_beat || w_rd_beat) && w_last;
            // A beat arriving on the expiry cycle wins over the abort.
            r_err      <= r_state == S_RD_WAIT && !m.ram_out_en && w_expired;
            if (w_rd_beat) r_rd_data <= m.ram_rdata;
            if (r_state == S_IDLE && m.cmd_valid) begin
                r_addr <= m.cmd_addr;
                r_cnt  <= m.cmd_len;
            end else if (w_wr_beat || w_rd_beat) begin
                r_addr <= r_addr + 1'b1;
                r_cnt  <= r_cnt - 1'b1;
            end
        end
    assign m.cmd_ready   = r_state == S_IDLE;
    assign m.wr_ready    = r_state == S_WR;
    assign m.rd_data     = r_rd_data;
    assign m.rd_valid    = r_rd_valid;
    assign m.done        = r_done;
    assign m.err_timeout = r_err;
    assign m.ram_en      = w_wr_beat || r_state == S_RD_ISSUE;
    assign m.ram_wr_rd   = r_state == S_WR;
    assign m.ram_addr    = (r_state == S_WR || r_state == S_RD_ISSUE) ? r_addr : '0;
    assign m.ram_wdata   = r_state == S_WR ? m.wr_data : '0;
endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: directed bench for the burst master against a behavioural single-port ram.
module tb_ram_burst_master;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] mem [16];
    logic [7:0] ram_q = 8'h00;
    logic       ram_oe = 1'b0;
    logic       kill = 1'b0;
    ram_burst_master_if bus ();
    ram_burst_master dut (.clk(clk), .rst(rst), .m(bus));
    always #5 clk = ~clk;
    // Ram model: registered read, out_en one cycle after a read enable; kill suppresses the strobe.
    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_wr_rd) mem[bus.ram_addr] <= bus.ram_wdata;
        ram_q  <= mem[bus.ram_addr];
        ram_oe <= bus.ram_en && !bus.ram_wr_rd && !kill;
    end
    assign bus.ram_rdata  = ram_q;
    assign bus.ram_out_en = ram_oe;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        bus.cmd_valid = 0; bus.cmd_wr = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
        bus.wr_data = 0; bus.wr_valid = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_ram_en", bus.ram_en, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err_timeout, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        rst = 0;
        @(negedge clk);
        // 1: write A0..A3 to 3..6 back-to-back
        bus.cmd_valid = 1; bus.cmd_wr = 1; bus.cmd_addr = 4'h3; bus.cmd_len = 4'h3;
        #1 chk("t1_cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 0;
        chk("t1_wr_ready", bus.wr_ready, 1);
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1; bus.wr_data = 8'hA0 + 8'(i);
            #1;
            chk("t1_ram_en", bus.ram_en, 1);
            chk("t1_ram_wr_rd", bus.ram_wr_rd, 1);
            chk("t1_ram_addr", bus.ram_addr, 3 + i);
            chk("t1_ram_wdata", bus.ram_wdata, 32'hA0 + i);
            chk("t1_no_early_done", bus.done, 0);
            @(negedge clk);
        end
        bus.wr_valid = 0;
        #1 chk("t1_done", bus.done, 1);
        chk("t1_idle", bus.cmd_ready, 1);
        @(negedge clk);
        chk("t1_done_pulse", bus.done, 0);
        for (int i = 0; i < 4; i++) chk("t1_mem", mem[3 + i], 32'hA0 + i);
        // 2: read back 3..6; rd_valid in cycles 3,5,7,9 after accept, done with the last
        bus.cmd_valid = 1; bus.cmd_wr = 0; bus.cmd_addr = 4'h3; bus.cmd_len = 4'h3;
        @(negedge clk);
        bus.cmd_valid = 0;
        chk("t2_issue_en", bus.ram_en, 1);
        chk("t2_issue_wr_rd", bus.ram_wr_rd, 0);
        chk("t2_issue_addr", bus.ram_addr, 3);
        for (int c = 1; c <= 10; c++) begin
            chk("t2_rd_valid", bus.rd_valid, (c == 3 || c == 5 || c == 7 || c == 9) ? 1 : 0);
            if (c == 3 || c == 5 || c == 7 || c == 9) chk("t2_rd_data", bus.rd_data, 32'hA0 + (c - 3) / 2);
            chk("t2_done", bus.done, c == 9 ? 1 : 0);
            @(negedge clk);
        end
        // 3: write E,F,0 (wrap) with a 2-cycle gap after the first beat
        bus.cmd_valid = 1; bus.cmd_wr = 1; bus.cmd_addr = 4'hE; bus.cmd_len = 4'h2;
        @(negedge clk);
        bus.cmd_valid = 0;
        bus.wr_valid = 1; bus.wr_data = 8'h51;
        #1 chk("t3_addr_e", bus.ram_addr, 4'hE);
        chk("t3_en0", bus.ram_en, 1);
        @(negedge clk);
        bus.wr_valid = 0;
        #1 chk("t3_gap1_en", bus.ram_en, 0);
        @(negedge clk);
        #1 chk("t3_gap2_en", bus.ram_en, 0);
        chk("t3_gap_ready", bus.wr_ready, 1);
        @(negedge clk);
        bus.wr_valid = 1; bus.wr_data = 8'h52;
        #1 chk("t3_addr_f", bus.ram_addr, 4'hF);
        @(negedge clk);
        bus.wr_data = 8'h53;
        #1 chk("t3_addr_wrap", bus.ram_addr, 4'h0);
        @(negedge clk);
        bus.wr_valid = 0;
        #1 chk("t3_done", bus.done, 1);
        @(negedge clk);
        chk("t3_mem_e", mem[14], 8'h51);
        chk("t3_mem_f", mem[15], 8'h52);
        chk("t3_mem_0", mem[0], 8'h53);
        // 4: no out_en; 8 RD_WAIT cycles (2..9) then err_timeout in cycle 10
        kill = 1;
        bus.cmd_valid = 1; bus.cmd_wr = 0; bus.cmd_addr = 4'h0; bus.cmd_len = 4'h3;
        @(negedge clk);
        bus.cmd_valid = 0;
        for (int c = 1; c <= 12; c++) begin
            chk("t4_err", bus.err_timeout, c == 10 ? 1 : 0);
            chk("t4_rd_valid", bus.rd_valid, 0);
            chk("t4_done", bus.done, 0);
            @(negedge clk);
        end
        chk("t4_idle", bus.cmd_ready, 1);
        kill = 0;
        // 5: reset during beat 2 issue of a 4-beat read
        bus.cmd_valid = 1; bus.cmd_wr = 0; bus.cmd_addr = 4'h3; bus.cmd_len = 4'h3;
        @(negedge clk);
        bus.cmd_valid = 0;
        @(negedge clk); @(negedge clk);
        chk("t5_beat1", bus.rd_valid, 1);
        chk("t5_beat1_data", bus.rd_data, 8'hA0);
        chk("t5_issue2_addr", bus.ram_addr, 4'h4);
        rst = 1;
        #1;
        chk("t5_rst_rd_valid", bus.rd_valid, 0);
        chk("t5_rst_rd_data", bus.rd_data, 0);
        chk("t5_rst_ram_en", bus.ram_en, 0);
        chk("t5_rst_ram_addr", bus.ram_addr, 0);
        chk("t5_rst_wr_rd", bus.ram_wr_rd, 0);
        chk("t5_rst_done", bus.done, 0);
        chk("t5_rst_err", bus.err_timeout, 0);
        chk("t5_rst_ready", bus.cmd_ready, 1);
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            chk("t5_quiet_rd_valid", bus.rd_valid, 0);
            chk("t5_quiet_done", bus.done, 0);
            @(negedge clk);
        end
        bus.cmd_valid = 1; bus.cmd_wr = 1; bus.cmd_addr = 4'h8; bus.cmd_len = 4'h0;
        @(negedge clk);
        bus.cmd_valid = 0;
        bus.wr_valid = 1; bus.wr_data = 8'h77;
        @(negedge clk);
        bus.wr_valid = 0;
        #1 chk("t5_wr_done", bus.done, 1);
        bus.cmd_valid = 1; bus.cmd_wr = 0; bus.cmd_addr = 4'h8; bus.cmd_len = 4'h0;
        @(negedge clk);
        bus.cmd_valid = 0;
        chk("t5_rd_issue_en", bus.ram_en, 1);
        chk("t5_rd_issue_addr", bus.ram_addr, 4'h8);
        @(negedge clk); @(negedge clk);
        chk("t5_rd_valid", bus.rd_valid, 1);
        chk("t5_rd_data", bus.rd_data, 8'h77);
        chk("t5_rd_done", bus.done, 1);
        @(negedge clk);
        chk("t5_done_pulse", bus.done, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
